prim_arbiter_wrr_lock: RTL and testbench

Weighted round-robin arbiter with packet locking. It shares one downstream ready/valid channel between N requesters. A grant is held from the first beat to the `last` beat of a packet, so packets never interleave. Each requester may send up to `weight` consecutive packets before priority rotates to the next requester. It sits in front of shared TL-UL/FIFO-style sinks and is the multi-beat, weighted counterpart of the single-beat arbiter primitives.

---
 rtl/prim_arbiter_wrr_lock_pkg.sv | 16 +
 rtl/prim_arbiter_wrr_lock_if.sv | 41 ++++
 rtl/prim_arbiter_wrr_lock_rr_pick.sv | 53 +++++
 rtl/prim_arbiter_wrr_lock.sv | 131 +++++++++++++
 tb/tb_prim_arbiter_wrr_lock.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prim_arbiter_wrr_lock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prim_arbiter_wrr_pkg                                                 |
// | Shared types for the weighted round-robin packet-locking arbiter.    |
// | Contents: arb_state_e - arbiter lock state (IDLE / LOCKED).          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package prim_arbiter_wrr_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/prim_arbiter_wrr_lock_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prim_arbiter_wrr_lock_if                                             |
// | Bundle of the requester side and downstream side of the arbiter.     |
// | Requester side : req_i[N], data_i[N*DW], last_i[N], weight_i[N*WW],  |
// |                  gnt_o[N]                                            |
// | Downstream side: valid_o, data_o[DW], last_o, idx_o, ready_i         |
// | Modports: slave  - the arbiter itself                                |
// |           master - the environment driving requests / ready          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface prim_arbiter_wrr_lock_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int WW = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    last_i;
  logic [N*WW-1:0] weight_i;
  logic [N-1:0]    gnt_o;
  logic [IW-1:0]   idx_o;
  logic            valid_o;
  logic [DW-1:0]   data_o;
  logic            last_o;
  logic            ready_i;

  modport slave (
    input  req_i, data_i, last_i, weight_i, ready_i,
    output gnt_o, idx_o, valid_o, data_o, last_o
  );

  modport master (
    output req_i, data_i, last_i, weight_i, ready_i,
    input  gnt_o, idx_o, valid_o, data_o, last_o
  );

endinterface
`default_nettype wire

// File: rtl/prim_arbiter_wrr_lock_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prim_rr_pick                                                         |
// | Circular first-one finder: returns the first set bit of req_i        |
// | scanning ptr_i, ptr_i+1, ..., N-1, 0, ...                            |
// | Ports: req_i[N] requests, ptr_i scan start,                          |
// |        found_o any request set, idx_o selected index (< N)           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module prim_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]                         req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic                                 found_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o
);
  localparam int            IW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0]   C_N = (IW+1)'(N);

  // Modulo-N add; both operands are < N so one subtraction suffices.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a,
                                             input logic [IW-1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= C_N) s = s - C_N;
    return s[IW-1:0];
  endfunction

  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;

  // Rotate so that position 0 of w_rot is the requester at ptr_i.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N; i++) begin
      w_rot[i] = req_i[wrap_add(ptr_i, IW'(i))];
    end
  end

  // Lowest set bit of the rotated vector is the nearest requester.
  always_comb begin
    w_off = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
  end

  assign found_o = |req_i;
  assign idx_o   = wrap_add(ptr_i, w_off);

endmodule
`default_nettype wire

// File: rtl/prim_arbiter_wrr_lock.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prim_arbiter_wrr_lock                                                |
// | Weighted round-robin arbiter with packet locking. Shares one         |
// | downstream ready/valid channel between N requesters; a grant is held |
// | from first beat to last beat, and each requester may send up to      |
// | weight packets per turn before priority rotates.                     |
// | Ports: clk_i, rst_i (sync, active high)                              |
// |        bus (slave modport): req/data/last/weight in, gnt out,        |
// |        valid/data/last/idx out, ready in                             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module prim_arbiter_wrr_lock
  import prim_arbiter_wrr_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int WW = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  prim_arbiter_wrr_lock_if.slave  bus
);
  localparam int          IW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0] C_N = (IW+1)'(N);

  arb_state_e    st_q, st_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] cnt_q, cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] sel;
  logic          sel_req;
  logic          sel_last;
  logic [DW-1:0] sel_data;
  logic [WW-1:0] sel_wt;
  logic          valid;
  logic          acc;
  logic [WW:0]   served;
  logic [WW:0]   wt_eff;
  logic [IW:0]   nxt_sum;
  logic [IW-1:0] sel_inc;

  prim_rr_pick #(.N(N)) u_pick (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Selection and per-requester field mux.
  always_comb begin
    sel      = (st_q == LOCKED) ? owner_q : pick_idx;
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    sel_wt   = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        sel_req  = bus.req_i[i];
        sel_last = bus.last_i[i];
        sel_data = bus.data_i[i*DW +: DW];
        sel_wt   = bus.weight_i[i*WW +: WW];
      end
    end
    // While locked only the owner counts: an owner bubble gives valid=0.
    valid = (st_q == LOCKED) ? sel_req : pick_found;
    acc   = valid && bus.ready_i;
  end

  // Credit arithmetic evaluated at packet end.
  always_comb begin
    served  = (sel == ptr_q) ? ({1'b0, cnt_q} + 1'b1) : (WW+1)'(1);
    wt_eff  = (sel_wt == '0) ? (WW+1)'(1) : {1'b0, sel_wt};
    nxt_sum = {1'b0, sel} + 1'b1;
    sel_inc = (nxt_sum == C_N) ? '0 : nxt_sum[IW-1:0];
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (acc) begin
      if (sel_last) begin
        st_d = IDLE;
        // An idle requester skipped over loses its remaining credit,
        // because ptr moves straight to the winner.
        if (served >= wt_eff) begin
          ptr_d = sel_inc;
          cnt_d = '0;
        end else begin
          ptr_d = sel;
          cnt_d = served[WW-1:0];
        end
      end else if (st_q == IDLE) begin
        st_d    = LOCKED;
        owner_d = sel;
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.valid_o = valid;
    bus.data_o  = valid ? sel_data : '0;
    bus.last_o  = valid ? sel_last : 1'b0;
    bus.idx_o   = valid ? sel : '0;
    bus.gnt_o   = acc ? (N'(1) << sel) : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_prim_arbiter_wrr_lock.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prim_arbiter_wrr_lock                                             |
// | Self-checking bench: directed scenarios with literal expectations    |
// | plus randomized traffic compared every cycle against a reference     |
// | model of the arbitration rules.                                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_prim_arbiter_wrr_lock;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic clk;
  logic rst_i;
  int   checks;
  int   failures;

  prim_arbiter_wrr_lock_if #(.N(N), .DW(DW), .WW(WW)) bus_if ();

  prim_arbiter_wrr_lock #(.N(N), .DW(DW), .WW(WW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_ok;
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cnt;

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int   s;
    logic ev;
    int   served;
    int   w;
    if (m_ok) begin
      s  = m_locked ? m_owner : first_from(bus_if.req_i, m_ptr);
      ev = (s >= 0) && bus_if.req_i[s];
      check("m_valid", 64'(bus_if.valid_o), 64'(ev));
      check("m_gnt",   64'(bus_if.gnt_o),   (ev && bus_if.ready_i) ? 64'(1) << s : 64'd0);
      check("m_idx",   64'(bus_if.idx_o),   ev ? 64'(s) : 64'd0);
      check("m_data",  64'(bus_if.data_o),  ev ? 64'(bus_if.data_i[s*DW +: DW]) : 64'd0);
      check("m_last",  64'(bus_if.last_o),  ev ? 64'(bus_if.last_i[s]) : 64'd0);
      if (!rst_i && ev && bus_if.ready_i) begin
        if (bus_if.last_i[s]) begin
          m_locked = 1'b0;
          served   = (s == m_ptr) ? m_cnt + 1 : 1;
          w        = int'(bus_if.weight_i[s*WW +: WW]);
          if (w == 0) w = 1;
          if (served >= w) begin
            m_ptr = (s + 1) % N;
            m_cnt = 0;
          end else begin
            m_ptr = s;
            m_cnt = served;
          end
        end else begin
          m_locked = 1'b1;
          m_owner  = s;
        end
      end
    end
    if (rst_i) begin
      m_ok = 1'b1; m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic do_reset;
    rst_i         = 1'b1;
    bus_if.req_i  = '0;
    bus_if.last_i = '0;
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic set_data;
    for (int i = 0; i < N; i++) bus_if.data_i[i*DW +: DW] = 32'hA000_0000 + 32'(i);
  endtask

  logic [N-1:0] pend;
  int           left [N];
  logic [N-1:0] g;
  int           rr_exp [5];
  int           wt_exp [8];

  initial begin
    checks = 0; failures = 0; m_ok = 1'b0;
    rst_i = 1'b1;
    bus_if.req_i = '0; bus_if.last_i = '0; bus_if.data_i = '0;
    bus_if.weight_i = '0; bus_if.ready_i = 1'b1;
    set_data();
    cyc();
    do_reset();

    // Reset state: no requests means all outputs zero.
    settle();
    check("rst_valid", 64'(bus_if.valid_o), 64'd0);
    check("rst_gnt",   64'(bus_if.gnt_o),   64'd0);
    check("rst_data",  64'(bus_if.data_o),  64'd0);
    cyc();

    // Plain round robin.
    rr_exp = '{0, 1, 2, 3, 0};
    bus_if.weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    bus_if.req_i = 4'hF; bus_if.last_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      settle(); check("rr_idx", 64'(bus_if.idx_o), 64'(rr_exp[k])); cyc();
    end

    // Weighted {3,1,2,1}.
    wt_exp = '{0, 0, 0, 1, 2, 2, 3, 0};
    bus_if.weight_i = {4'd1, 4'd2, 4'd1, 4'd3};
    do_reset();
    bus_if.req_i = 4'hF; bus_if.last_i = 4'hF;
    for (int k = 0; k < 8; k++) begin
      settle(); check("wrr_idx", 64'(bus_if.idx_o), 64'(wt_exp[k])); cyc();
    end

    // Lock with owner bubble.
    bus_if.weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    bus_if.req_i = 4'b0010; bus_if.last_i = 4'b0000;
    settle(); check("lock_b1_gnt", 64'(bus_if.gnt_o), 64'b0010); cyc();
    bus_if.req_i = 4'b0011; bus_if.last_i = 4'b0001;
    settle(); check("lock_b2_idx", 64'(bus_if.idx_o), 64'd1); cyc();
    bus_if.req_i = 4'b0001;
    settle(); check("lock_bub_valid", 64'(bus_if.valid_o), 64'd0);
    check("lock_bub_gnt", 64'(bus_if.gnt_o), 64'd0); cyc();
    bus_if.req_i = 4'b0011; bus_if.last_i = 4'b0001;
    settle(); check("lock_b3_idx", 64'(bus_if.idx_o), 64'd1); cyc();
    bus_if.last_i = 4'b0011;
    settle(); check("lock_b4_idx", 64'(bus_if.idx_o), 64'd1);
    check("lock_b4_last", 64'(bus_if.last_o), 64'd1); cyc();
    bus_if.req_i = 4'b0001;
    settle(); check("lock_after_gnt", 64'(bus_if.gnt_o), 64'b0001); cyc();
    bus_if.req_i = '0; cyc();

    // Backpressure mid-packet, weight 0 acts as 1.
    bus_if.weight_i = '0;
    do_reset();
    bus_if.req_i = 4'b1000; bus_if.last_i = 4'b0000;
    settle(); check("bp_first_gnt", 64'(bus_if.gnt_o), 64'b1000); cyc();
    bus_if.data_i[3*DW +: DW] = 32'hB0B0_1234; bus_if.ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_gnt", 64'(bus_if.gnt_o), 64'd0);
      check("bp_data", 64'(bus_if.data_o), 64'hB0B0_1234);
      cyc();
    end
    bus_if.ready_i = 1'b1; bus_if.last_i = 4'b1000;
    settle(); check("bp_last_gnt", 64'(bus_if.gnt_o), 64'b1000); cyc();
    bus_if.req_i = 4'b1001; bus_if.last_i = 4'b1001;
    settle(); check("w0_rotate_idx", 64'(bus_if.idx_o), 64'd0); cyc();
    set_data();

    // Skip / forfeit: requester 2 (weight 3) has credit left, then goes idle.
    bus_if.weight_i = {4'd1, 4'd3, 4'd1, 4'd1};
    do_reset();
    bus_if.last_i = 4'hF;
    bus_if.req_i = 4'b0100; settle(); check("skip_a_idx", 64'(bus_if.idx_o), 64'd2); cyc();
    bus_if.req_i = 4'b1000; settle(); check("skip_b_idx", 64'(bus_if.idx_o), 64'd3); cyc();
    bus_if.req_i = 4'b1111; settle(); check("skip_c_idx", 64'(bus_if.idx_o), 64'd0); cyc();

    // Reset mid-packet.
    bus_if.weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    bus_if.req_i = 4'b1000; bus_if.last_i = 4'b0000;
    settle(); check("rmp_b1_idx", 64'(bus_if.idx_o), 64'd3); cyc();
    bus_if.req_i = 4'b1001; rst_i = 1'b1;
    settle(); check("rmp_b2_idx", 64'(bus_if.idx_o), 64'd3); cyc();
    rst_i = 1'b0;
    settle();
    check("rmp_after_idx", 64'(bus_if.idx_o), 64'd0);
    check("rmp_after_valid", 64'(bus_if.valid_o), 64'd1);
    cyc();
    bus_if.req_i = '0; cyc();

    // Randomized traffic; requesters hold a beat until it is granted.
    do_reset();
    pend = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < N; i++) bus_if.weight_i[i*WW +: WW] = WW'($urandom_range(0, 4));
      for (int c = 0; c < 800; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom_range(0, 9) < 6) begin
            if (left[i] == 0) left[i] = $urandom_range(1, 4);
            pend[i] = 1'b1;
            bus_if.data_i[i*DW +: DW] = $urandom;
            bus_if.last_i[i] = (left[i] == 1);
          end
          if (!pend[i]) begin
            bus_if.data_i[i*DW +: DW] = '0;
            bus_if.last_i[i] = 1'b0;
          end
        end
        bus_if.req_i   = pend;
        bus_if.ready_i = ($urandom_range(0, 3) != 0);
        rst_i          = ($urandom_range(0, 199) == 0);
        #8;
        g = bus_if.gnt_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
          if (g[i]) begin
            pend[i] = 1'b0;
            left[i] = left[i] - 1;
          end
        end
      end
    end
    rst_i = 1'b0; bus_if.req_i = '0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
